// File: rtl/copro_io_master_if.sv
// Command/response handshake between the debug transport and copro_io_master.
interface copro_io_master_if #(
  parameter int N      = 64,
  parameter int ADDR_W = 15
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [2:0]        cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [N-1:0]      cmd_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [N-1:0]      resp_data;
  logic              resp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_sel, cmd_addr, cmd_data, resp_ready,
    output cmd_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sel, cmd_addr, cmd_data, resp_ready,
    input  cmd_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/copro_io_master.sv
// Debug-command initiator for the core's coprocessor IO port: drives registered
// Addr/Control/DataOut timing and returns sampled DataIn on a response channel.
module copro_io_master #(
  parameter int          N            = 64,
  parameter int          ADDR_W       = 15,
  parameter int          READ_LATENCY = 2,
  parameter logic [63:0] MAGIC        = 64'h00000000feedc0de
) (
  input  logic              clk,
  input  logic              reset,
  copro_io_master_if.master host,
  output logic              armed,
  output logic              break_hit,
  output logic [ADDR_W-1:0] coprocessorIOAddr,
  output logic [4:0]        coprocessorIOControl,
  output logic [N-1:0]      coprocessorIODataOut,
  input  logic [N-1:0]      coprocessorIODataIn
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [2:0] {
    OP_MEM_READ  = 3'b000,
    OP_PORT_READ = 3'b001,
    OP_ARM       = 3'b010,
    OP_DISARM    = 3'b011
  } op_e;

  localparam logic [N-1:0]      MAGIC_N  = N'(MAGIC);
  localparam logic [2:0]        LAT_LAST = 3'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] BP_ADDR  = ADDR_W'(32'h1000);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              is_read_q, is_read_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [N-1:0]      resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              armed_q, armed_d;
  logic              break_hit_q, break_hit_d;
  logic [4:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]      dout_q, dout_d;

  logic op_read, op_legal, accept, access_done;

  always_comb begin
    op_read  = (host.cmd_op == OP_MEM_READ) || (host.cmd_op == OP_PORT_READ);
    op_legal = (host.cmd_op inside {OP_MEM_READ, OP_PORT_READ, OP_ARM, OP_DISARM}) &&
               !((host.cmd_op == OP_PORT_READ) && (host.cmd_sel == 3'b000));
  end

  assign accept      = (state_q == S_IDLE) && cmd_ready_q && host.cmd_valid;
  assign access_done = ((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                       (!is_read_q || (cnt_q == 3'd0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_read_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      armed_q      <= 1'b0;
      break_hit_q  <= 1'b0;
      ctrl_q       <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_read_q    <= is_read_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      armed_q      <= armed_d;
      break_hit_q  <= break_hit_d;
      ctrl_q       <= ctrl_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
    end
  end

  // Reads hold the access for cnt+1 cycles; ARM/DISARM leave after one ISSUE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = op_legal ? S_ISSUE : S_RESP;
          cnt_d   = LAT_LAST;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (access_done) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (host.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_read_d    = is_read_q;
    cmd_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    armed_d      = armed_q;
    break_hit_d  = break_hit_q;
    ctrl_d       = ctrl_q;
    addr_d       = addr_q;
    dout_d       = dout_q;

    if (armed_q && (state_q == S_IDLE) && (ctrl_q[3:0] == 4'b0000) &&
        (coprocessorIODataIn == MAGIC_N))
      break_hit_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_read_d   = op_read && op_legal;
          resp_data_d = '0;
          resp_err_d  = !op_legal;
          if (op_legal) begin
            case (host.cmd_op)
              OP_MEM_READ: begin
                ctrl_d = {armed_q, 4'b1000};
                addr_d = host.cmd_addr;
              end
              OP_PORT_READ: begin
                ctrl_d = {armed_q, 1'b0, host.cmd_sel};
                addr_d = host.cmd_addr;
              end
              OP_ARM: begin
                ctrl_d      = 5'b11000;
                addr_d      = BP_ADDR;
                dout_d      = host.cmd_data;
                armed_d     = 1'b1;
                break_hit_d = 1'b0;
              end
              default: begin
                ctrl_d      = '0;
                addr_d      = '0;
                armed_d     = 1'b0;
                break_hit_d = 1'b0;
              end
            endcase
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        if (access_done) begin
          ctrl_d = {armed_q, 4'b0000};
          addr_d = '0;
          dout_d = '0;
          if (is_read_q) resp_data_d = coprocessorIODataIn;
        end
      end
      default: ;
    endcase
  end

  assign host.cmd_ready       = cmd_ready_q;
  assign host.resp_valid      = resp_valid_q;
  assign host.resp_data       = resp_data_q;
  assign host.resp_err        = resp_err_q;
  assign armed                = armed_q;
  assign break_hit            = break_hit_q;
  assign coprocessorIOAddr    = addr_q;
  assign coprocessorIOControl = ctrl_q;
  assign coprocessorIODataOut = dout_q;

endmodule
